pc_fetch: RTL and testbench
===========================

PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 RESET_PC, 32'h0000_0000, address of the first fetch after reset.
REQ-002 PC_WIDTH, 32, address/instruction width; bits [1:0] of every generated PC SHALL be 0.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 bpu_current_pc  output  PC_WIDTH  PC presented to the branch predictor for lookup; equals fetch PC register.
REQ-006 bpu_predicted_pc  input  PC_WIDTH  predictor's combinational next-PC for bpu_current_pc.
REQ-007 redirect_valid  input  1  mispredict correction from MEM stage.
REQ-008 redirect_pc  input  PC_WIDTH  corrected next PC, valid with redirect_valid.
REQ-009 imem_req / imem_addr  output  1 / PC_WIDTH  instruction-memory request and address.
REQ-010 imem_ack / imem_rdata  input  1 / PC_WIDTH  request completion and instruction word, same cycle.
REQ-011 if_valid / if_pc / if_instr / if_pred_pc  output  1 / PC_WIDTH x3  registered fetch result to decode.
REQ-012 if_ready  input  1  decode accepts result when if_valid && if_ready (includes hazard stall).

Function
REQ-013 States: FETCH (imem_req=1), FULL (output register occupied, no request), DRAIN (discarding an outstanding request).
REQ-014 imem_addr SHALL equal the fetch PC and stay stable while imem_req=1 and imem_ack=0.
REQ-015 FETCH + imem_ack: capture pc/rdata/next-PC into output register (if_valid=1 next cycle); fetch PC <= next-PC.
REQ-016 Next-PC = bpu_predicted_pc sampled at the ack cycle; if_pred_pc carries it for MEM comparison.
REQ-017 FETCH continues back-to-back (one instruction per cycle with single-cycle ack) while output register is empty or consumed in the ack cycle; otherwise FETCH -> FULL.
REQ-018 FULL -> FETCH when output consumed; imem_req=0 in FULL.
REQ-019 redirect_valid has priority over all events: if_valid <= 0, fetch PC <= redirect_pc.
REQ-020 Redirect in FETCH with imem_ack=0: -> DRAIN; req held at old address; on ack data dropped, -> FETCH at redirect_pc.
REQ-021 Redirect coinciding with imem_ack: data dropped, -> FETCH at redirect_pc, no DRAIN.
REQ-022 Redirect during DRAIN: latest redirect_pc wins; remain in DRAIN until ack.
REQ-023 Output register SHALL not change while if_valid=1 and if_ready=0, except on redirect.
REQ-024 PC arithmetic modulo 2^PC_WIDTH; 32'hFFFF_FFFC + 4 wraps to 0.

Reset
REQ-025 While reset=0: state FETCH, fetch PC = RESET_PC, if_valid=0, if_pc/if_instr/if_pred_pc=0, imem_req=0.
REQ-026 First cycle after release: imem_req=1, imem_addr=RESET_PC; reset mid-request abandons it (imem shares reset).

Configuration
REQ-027 PC_FETCH_PREDICT_EN defined: next-PC from bpu_predicted_pc; undefined: next-PC = pc+4, bpu_current_pc driven 0, bpu_predicted_pc ignored.

Structure
REQ-028 Package pc_fetch_pkg: PC_WIDTH, RESET_PC default, state enum {FETCH, FULL, DRAIN}.
REQ-029 Sub-module pc_fetch_out_reg: output holding register with valid/ready and flush.

Verification
REQ-030 Reset release, ack every cycle, predictor = pc+4 -> if_pc 0,4,8,12 on consecutive cycles.
REQ-031 Predictor returns 0x40 for pc 0x8 -> if_pc sequence 0x8, 0x40, if_pred_pc(0x8)=0x40.
REQ-032 if_ready=0 for 3 cycles -> FULL, imem_req=0, outputs frozen; if_ready=1 -> fetch resumes next cycle.
REQ-033 Redirect to 0x100 while ack delayed 2 cycles -> DRAIN, stale data never reaches if_valid, next imem_addr=0x100.
REQ-034 Redirect and ack same cycle -> no if_valid for that data, imem_addr=redirect_pc next cycle.
REQ-035 PC_FETCH_PREDICT_EN undefined, predictor forced 0x40 -> sequence stays pc+4.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// rtl/pc_fetch_pkg.sv - shared widths, reset address and fetch state encoding
package pc_fetch_pkg;
  localparam int PC_WIDTH = 32;
  localparam logic [PC_WIDTH-1:0] RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    FULL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic logic [PC_WIDTH-1:0] align_pc(input logic [PC_WIDTH-1:0] pc);
    return {pc[PC_WIDTH-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/pc_fetch_out_reg.sv
// rtl/pc_fetch_out_reg.sv - fetch result holding register with valid/ready handshake and flush
module pc_fetch_out_reg
  import pc_fetch_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                load,
  input  logic [PC_WIDTH-1:0] in_pc,
  input  logic [PC_WIDTH-1:0] in_instr,
  input  logic [PC_WIDTH-1:0] in_pred_pc,
  input  logic                ready,
  output logic                valid,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0] pred_pc,
  output logic                free
);
  // Free means a load this cycle cannot overwrite unconsumed data.
  assign free = !valid || ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid   <= 1'b0;
      pc      <= '0;
      instr   <= '0;
      pred_pc <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid   <= 1'b1;
      pc      <= in_pc;
      instr   <= in_instr;
      pred_pc <= in_pred_pc;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - fetch PC sequencer: imem request, predictor hook, redirect drain
// Build option PC_FETCH_PREDICT_EN takes next-PC from the branch predictor instead of pc+4.
module pc_fetch
  import pc_fetch_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  output logic [PC_WIDTH-1:0] bpu_current_pc,
  input  logic [PC_WIDTH-1:0] bpu_predicted_pc,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [PC_WIDTH-1:0] imem_rdata,
  output logic                if_valid,
  output logic [PC_WIDTH-1:0] if_pc,
  output logic [PC_WIDTH-1:0] if_instr,
  output logic [PC_WIDTH-1:0] if_pred_pc,
  input  logic                if_ready
);
  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] drain_addr_q, drain_addr_d;
  logic [PC_WIDTH-1:0] next_pc;
  logic                load, flush, out_free;

`ifdef PC_FETCH_PREDICT_EN
  assign next_pc        = align_pc(bpu_predicted_pc);
  assign bpu_current_pc = pc_q;
`else
  logic unused_pred;
  assign unused_pred    = ^bpu_predicted_pc;
  assign next_pc        = pc_q + PC_WIDTH'(4);
  assign bpu_current_pc = '0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
    end
  end

  // An ack that finds the output register blocked is dropped without advancing
  // the PC; the same address is fetched again once decode drains the register.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    load         = 1'b0;
    flush        = 1'b0;
    unique case (state_q)
      FETCH: begin
        if (redirect_valid) begin
          flush = 1'b1;
          pc_d  = align_pc(redirect_pc);
          if (!imem_ack) begin
            state_d      = DRAIN;
            drain_addr_d = pc_q;
          end
        end else if (imem_ack) begin
          if (out_free) begin
            load = 1'b1;
            pc_d = next_pc;
          end else begin
            state_d = FULL;
          end
        end
      end
      FULL: begin
        if (redirect_valid) begin
          flush   = 1'b1;
          pc_d    = align_pc(redirect_pc);
          state_d = FETCH;
        end else if (out_free) begin
          state_d = FETCH;
        end
      end
      DRAIN: begin
        if (redirect_valid) begin
          flush = 1'b1;
          pc_d  = align_pc(redirect_pc);
        end
        if (imem_ack) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    imem_req  = reset && (state_q == FETCH || state_q == DRAIN);
    imem_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;
  end

  pc_fetch_out_reg u_out_reg (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .load       (load),
    .in_pc      (pc_q),
    .in_instr   (imem_rdata),
    .in_pred_pc (next_pc),
    .ready      (if_ready),
    .valid      (if_valid),
    .pc         (if_pc),
    .instr      (if_instr),
    .pred_pc    (if_pred_pc),
    .free       (out_free)
  );
endmodule

// File: tb/tb_pc_fetch.sv
// tb/tb_pc_fetch.sv - directed and randomized self-checking bench for pc_fetch
module tb_pc_fetch;
  localparam logic [31:0] KEY = 32'h5A5A_1234;

  logic        clk, reset;
  logic [31:0] bpu_current_pc, bpu_predicted_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        if_valid, if_ready;
  logic [31:0] if_pc, if_instr, if_pred_pc;

  int          tests = 0;
  int          fails = 0;
  int          pred_mode = 0;

  function automatic logic [31:0] pred_fn(input int mode, input logic [31:0] pc);
    if (mode == 2) return 32'h40;
    if (mode == 1) begin
      if (pc == 32'h8) return 32'h40;
      if (pc[5:2] == 4'hB) return pc - 32'h20;
    end
    return pc + 32'd4;
  endfunction

  function automatic logic [31:0] model_next(input int mode, input logic [31:0] pc);
`ifdef PC_FETCH_PREDICT_EN
    return pred_fn(mode, pc);
`else
    return pc + 32'd4 + 32'(mode * 0);
`endif
  endfunction

  assign imem_rdata       = imem_addr ^ KEY;
  assign bpu_predicted_pc = pred_fn(pred_mode, bpu_current_pc);

  pc_fetch dut (
    .clk              (clk),
    .reset            (reset),
    .bpu_current_pc   (bpu_current_pc),
    .bpu_predicted_pc (bpu_predicted_pc),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ack         (imem_ack),
    .imem_rdata       (imem_rdata),
    .if_valid         (if_valid),
    .if_pc            (if_pc),
    .if_instr         (if_instr),
    .if_pred_pc       (if_pred_pc),
    .if_ready         (if_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, 32'(if_valid), 32'd1);
    chk({tag, "_pc"}, if_pc, pc);
    chk({tag, "_instr"}, if_instr, pc ^ KEY);
  endtask

  logic [31:0] exp_pc, exp_nx, prev_addr, prev_pc, prev_instr, prev_pred;
  logic        prev_pending, prev_hold, prev_redirect;
  int          hs;

  initial begin
    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_ack = 1'b0; if_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_pred", if_pred_pc, 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);

    // Release, ack every cycle, sequential predictor
    reset = 1'b1; #1;
    chk("rel_req", 32'(imem_req), 32'd1);
    chk("rel_addr", imem_addr, 32'h0);
    imem_ack = 1'b1; if_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_out("seq", 32'(4 * i));
      chk("seq_pred", if_pred_pc, 32'(4 * i + 4));
    end

    // Decode stall: three cycles of if_ready=0
    if_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("full_req", 32'(imem_req), 32'd0);
      chk_out("full", 32'd12);
    end
    if_ready = 1'b1;
    @(negedge clk);
    chk("resume_req", 32'(imem_req), 32'd1);
    chk("resume_addr", imem_addr, 32'd16);
    chk("resume_valid", 32'(if_valid), 32'd0);
    @(negedge clk);
    chk_out("resume", 32'd16);

    // Redirect while the ack is delayed two cycles
    imem_ack = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("drain_valid0", 32'(if_valid), 32'd0);
    chk("drain_addr0", imem_addr, 32'd20);
    @(negedge clk);
    chk("drain_valid1", 32'(if_valid), 32'd0);
    chk("drain_addr1", imem_addr, 32'd20);
    imem_ack = 1'b1;
    @(negedge clk);
    chk("drain_exit_valid", 32'(if_valid), 32'd0);
    chk("drain_exit_addr", imem_addr, 32'h100);
    @(negedge clk);
    chk_out("drain_tgt", 32'h100);

    // Two redirects during one drain: the later target wins
    imem_ack = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h300;
    @(negedge clk);
    redirect_pc = 32'h340;
    @(negedge clk);
    redirect_valid = 1'b0; imem_ack = 1'b1;
    chk("redrain_addr", imem_addr, 32'h104);
    chk("redrain_valid", 32'(if_valid), 32'd0);
    @(negedge clk);
    chk("redrain_tgt", imem_addr, 32'h340);

    // Redirect coinciding with ack
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("racks_valid", 32'(if_valid), 32'd0);
    chk("racks_addr", imem_addr, 32'h200);
    @(negedge clk);
    chk_out("racks", 32'h200);

    // Address wrap at the top of the space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    @(negedge clk);
    chk_out("wrap_top", 32'hFFFF_FFFC);
    chk("wrap_pred", if_pred_pc, 32'h0);
    @(negedge clk);
    chk_out("wrap_zero", 32'h0);

    // Predictor steering at pc 0x8
`ifdef PC_FETCH_PREDICT_EN
    pred_mode = 1;
    exp_nx = 32'h40;
`else
    pred_mode = 2;
    exp_nx = 32'hC;
`endif
    redirect_valid = 1'b1; redirect_pc = 32'h8;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("bp_addr", imem_addr, 32'h8);
`ifdef PC_FETCH_PREDICT_EN
    chk("bp_cur", bpu_current_pc, 32'h8);
`else
    chk("bp_cur", bpu_current_pc, 32'h0);
`endif
    @(negedge clk);
    chk_out("bp_src", 32'h8);
    chk("bp_pred", if_pred_pc, exp_nx);
    @(negedge clk);
    chk_out("bp_dst", exp_nx);

    // Randomized traffic against a program-order stream model
    pred_mode = 1;
    exp_pc = '0; hs = 0;
    prev_pending = 1'b0; prev_hold = 1'b0; prev_redirect = 1'b0;
    prev_addr = '0; prev_pc = '0; prev_instr = '0; prev_pred = '0;
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) @(negedge clk);
      if (prev_pending) begin
        chk("rnd_req_held", 32'(imem_req), 32'd1);
        chk("rnd_addr_stable", imem_addr, prev_addr);
      end
      if (prev_hold) begin
        chk("rnd_freeze_valid", 32'(if_valid), 32'd1);
        chk("rnd_freeze_pc", if_pc, prev_pc);
        chk("rnd_freeze_instr", if_instr, prev_instr);
        chk("rnd_freeze_pred", if_pred_pc, prev_pred);
      end
      if (prev_redirect) chk("rnd_flush", 32'(if_valid), 32'd0);
      if (imem_req) chk("rnd_align", 32'(imem_addr[1:0]), 32'd0);
`ifndef PC_FETCH_PREDICT_EN
      chk("rnd_bpu_zero", bpu_current_pc, 32'd0);
`endif
      imem_ack       = imem_req && ($urandom_range(3) != 0);
      if_ready       = (c != 0) && ($urandom_range(3) != 0);
      redirect_valid = (c == 0) || ($urandom_range(31) == 0);
      redirect_pc    = (c == 0) ? 32'h80 : ($urandom_range(255) << 2);
      #1;
      if (if_valid && if_ready) begin
        hs++;
        chk("rnd_pc", if_pc, exp_pc);
        chk("rnd_instr", if_instr, exp_pc ^ KEY);
        chk("rnd_pred", if_pred_pc, model_next(pred_mode, exp_pc));
        exp_pc = model_next(pred_mode, exp_pc);
      end
      if (redirect_valid) exp_pc = redirect_pc;
      prev_pending  = imem_req && !imem_ack;
      prev_addr     = imem_addr;
      prev_hold     = if_valid && !if_ready && !redirect_valid;
      prev_pc       = if_pc;
      prev_instr    = if_instr;
      prev_pred     = if_pred_pc;
      prev_redirect = redirect_valid;
    end
    chk("rnd_progress", 32'(hs > 300), 32'd1);

    // Reset in the middle of an outstanding request
    @(negedge clk);
    redirect_valid = 1'b0; imem_ack = 1'b0; if_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(if_valid), 32'd0);
    chk("mid_rst_req", 32'(imem_req), 32'd0);
    reset = 1'b1; #1;
    chk("mid_rel_addr", imem_addr, 32'h0);
    chk("mid_rel_req", 32'(imem_req), 32'd1);
    imem_ack = 1'b1;
    @(negedge clk);
    chk_out("mid_first", 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
